fp_unit_arbiter: RTL and testbench



---
 rtl/fp_unit_arbiter.sv | 143 ++++++++++++++
 tb/tb_fp_unit_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unit_arbiter.sv
// Round-robin share of one valid/ready FP unit among NUM_REQ requesters; results routed back by an in-order tag FIFO.
// Latency: zero-cycle combinational issue and response paths; tag FIFO, rr_ptr, outstanding and proto_err update on the clock edge.
// Backpressure: issue stalls on unit_in_ready or when MAX_OUT tags are in flight; unit_out_ready follows the head requester's rsp_ready.
// Build option: define FP_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fp_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 64,
    parameter int RSP_W   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*REQ_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [RSP_W-1:0]           rsp_data,
    output logic                       unit_in_valid,
    input  logic                       unit_in_ready,
    output logic [REQ_W-1:0]           unit_in_data,
    input  logic                       unit_out_valid,
    output logic                       unit_out_ready,
    input  logic [RSP_W-1:0]           unit_out_data,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       proto_err
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;

    logic [TAG_W-1:0]   tag_mem [MAX_OUT];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [TAG_W-1:0]   head;
    logic               full;
    logic               empty;
    logic               issue_fire;
    logic               rsp_fire;

    // Pick the first valid requester at or after rr_ptr, wrapping; independent of any ready.
    always_comb begin : grant_sel
        logic [TAG_W:0] cand;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (TAG_W+1)'(k);
            if (cand >= (TAG_W+1)'(NUM_REQ)) begin
                cand = cand - (TAG_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[cand[TAG_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[TAG_W-1:0];
            end
        end
        grant = '0;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign full       = (outstanding == CNT_W'(MAX_OUT));
    assign empty      = (outstanding == '0);
    assign head       = tag_mem[rd_ptr];
    assign issue_fire = unit_in_valid && unit_in_ready;
    assign rsp_fire   = unit_out_valid && unit_out_ready;

    // Issue side: full is registered state only, so a same-cycle pop never frees a slot.
    always_comb begin
        unit_in_valid = grant_any && !full;
        unit_in_data  = req_data[grant_idx*REQ_W +: REQ_W];
        req_ready     = (unit_in_ready && !full) ? grant : '0;
    end

    // Response side: steer the result to the requester whose tag sits at the FIFO head.
    always_comb begin
        rsp_valid = '0;
        if (unit_out_valid && !empty) begin
            rsp_valid[head] = 1'b1;
        end
        rsp_data       = unit_out_data;
        unit_out_ready = !empty && rsp_ready[head];
    end

`ifdef FP_ARB_FIXED_PRIO_EN
    // Fixed priority: scan always starts at requester 0.
    assign rr_ptr = '0;
`else
    // Advance the round-robin pointer past the requester that was just issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (issue_fire) begin
            rr_ptr <= (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + TAG_W'(1);
        end
    end
`endif

    // Tag FIFO storage: write the granted index on every issue.
    always_ff @(posedge clock) begin
        if (issue_fire) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    // FIFO pointers and in-flight count; reset discards all pending tags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (issue_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rsp_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (issue_fire && !rsp_fire) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!issue_fire && rsp_fire) begin
                outstanding <= outstanding - CNT_W'(1);
            end
        end
    end

    // Sticky flag for a result arriving with no tag pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (unit_out_valid && empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter: reset-time vector table plus multi-cycle sequences.
// Latency: inputs driven 1ns after the rising edge, outputs compared 1ns later.
// Backpressure: exercised via unit_in_ready, rsp_ready and the MAX_OUT limit.
module tb_fp_unit_arbiter;

    localparam int NUM_REQ = 4;
    localparam int REQ_W   = 64;
    localparam int RSP_W   = 32;
    localparam int MAX_OUT = 4;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*REQ_W-1:0] req_data;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [RSP_W-1:0]         rsp_data;
    logic                     unit_in_valid;
    logic                     unit_in_ready;
    logic [REQ_W-1:0]         unit_in_data;
    logic                     unit_out_valid;
    logic                     unit_out_ready;
    logic [RSP_W-1:0]         unit_out_data;
    logic [$clog2(MAX_OUT):0] outstanding;
    logic                     proto_err;

    // Result source: either a 2-stage unit model or direct drive.
    logic             use_model;
    logic             man_vld;
    logic [RSP_W-1:0] man_dat;
    logic             m1_vld, m2_vld;
    logic [RSP_W-1:0] m1_dat, m2_dat;

    int n_vec;
    int n_err;

    fp_unit_arbiter #(
        .NUM_REQ(NUM_REQ), .REQ_W(REQ_W), .RSP_W(RSP_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .unit_in_valid(unit_in_valid), .unit_in_ready(unit_in_ready), .unit_in_data(unit_in_data),
        .unit_out_valid(unit_out_valid), .unit_out_ready(unit_out_ready), .unit_out_data(unit_out_data),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Latency-2 unit model; returns the low word of the issued payload.
    always @(posedge clock) begin
        if (reset) begin
            m1_vld <= 1'b0;
            m2_vld <= 1'b0;
            m1_dat <= '0;
            m2_dat <= '0;
        end else begin
            m1_vld <= unit_in_valid && unit_in_ready;
            m1_dat <= unit_in_data[RSP_W-1:0];
            m2_vld <= m1_vld;
            m2_dat <= m1_dat;
        end
    end

    assign unit_out_valid = use_model ? m2_vld : man_vld;
    assign unit_out_data  = use_model ? m2_dat : man_dat;

    function automatic logic [63:0] pat(input int i);
        return {32'hA5A5_0000 + 32'(i), 32'hC0DE_0010 + 32'(i)};
    endfunction

    function automatic logic [31:0] res(input int i);
        return 32'hC0DE_0010 + 32'(i);
    endfunction

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       uir;
        logic [3:0] exp_rdy;
        logic       exp_uiv;
        int         exp_idx;
    } vec_t;

    vec_t vecs[8];

    logic [3:0] exp_g [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        unit_in_ready = 1'b0;
        use_model = 1'b0;
        man_vld = 1'b0;
        man_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*REQ_W +: REQ_W] = pat(i);

        // Held in reset: rr_ptr=0 and FIFO empty, so issue outputs are pure functions of the inputs.
        vecs[0] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};
        vecs[1] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 0};
        vecs[2] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};
        vecs[3] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1};
        vecs[4] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 3};
        vecs[5] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0};
        vecs[6] = '{4'b1100, 1'b0, 4'b0000, 1'b1, 2};
        vecs[7] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2};

        tick();
        tick();
        for (int v = 0; v < 8; v++) begin
            req_valid     = vecs[v].rv;
            unit_in_ready = vecs[v].uir;
            man_vld       = 1'b1;
            rsp_ready     = 4'hF;
            #1;
            chk("tbl_req_ready", 64'(req_ready), 64'(vecs[v].exp_rdy));
            chk("tbl_unit_in_valid", 64'(unit_in_valid), 64'(vecs[v].exp_uiv));
            if (vecs[v].exp_uiv) chk("tbl_unit_in_data", unit_in_data, pat(vecs[v].exp_idx));
            chk("tbl_rst_outstanding", 64'(outstanding), 64'd0);
            chk("tbl_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("tbl_rst_unit_out_ready", 64'(unit_out_ready), 64'd0);
            chk("tbl_rst_proto_err", 64'(proto_err), 64'd0);
            tick();
        end

        // Round-robin with the latency-2 model: grants 0,1,2,3,0 and results in the same order.
        reset = 1'b0;
        man_vld = 1'b0;
        use_model = 1'b1;
        rsp_ready = 4'hF;
        unit_in_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 5) ? 4'hF : 4'h0;
            #1;
            chk("rr_req_ready", 64'(req_ready), (c < 5) ? 64'(oh(c % 4)) : 64'd0);
            if (c < 5) chk("rr_unit_in_data", unit_in_data, pat(c % 4));
            chk("rr_outstanding", 64'(outstanding), (c == 0) ? 64'd0 : (c == 1 || c == 6) ? 64'd1 : 64'd2);
            if (c >= 2) begin
                chk("rr_rsp_valid", 64'(rsp_valid), 64'(oh((c - 2) % 4)));
                chk("rr_rsp_data", 64'(rsp_data), 64'(res((c - 2) % 4)));
            end
            tick();
        end
        chk("rr_drained", 64'(outstanding), 64'd0);
        use_model = 1'b0;

        // Full stall: rr_ptr is 1, four issues fill the unit.
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'hF;
            #1;
            chk("full_fill_req_ready", 64'(req_ready), 64'(oh((c + 1) % 4)));
            chk("full_fill_outstanding", 64'(outstanding), 64'(c));
            tick();
        end
        man_vld = 1'b1;
        man_dat = 32'h1234_5678;
        #1;
        chk("full_outstanding", 64'(outstanding), 64'd4);
        chk("full_req_ready", 64'(req_ready), 64'd0);
        chk("full_unit_in_valid", 64'(unit_in_valid), 64'd0);
        chk("full_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("full_unit_out_ready", 64'(unit_out_ready), 64'd1);
        chk("full_rsp_data", 64'(rsp_data), 64'h1234_5678);
        tick();
        man_vld = 1'b0;
        #1;
        chk("after_pop_outstanding", 64'(outstanding), 64'd3);
        chk("after_pop_req_ready", 64'(req_ready), 64'b0010);
        chk("after_pop_unit_in_valid", 64'(unit_in_valid), 64'd1);
        tick();

        // Backpressure on requester 2 (FIFO now holds tags 2,3,0,1).
        req_valid = 4'h0;
        man_vld = 1'b1;
        man_dat = 32'hBEEF_0002;
        rsp_ready = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_rsp_valid", 64'(rsp_valid), 64'b0100);
            chk("bp_unit_out_ready", 64'(unit_out_ready), 64'd0);
            chk("bp_rsp_data", 64'(rsp_data), 64'hBEEF_0002);
            chk("bp_outstanding", 64'(outstanding), 64'd4);
            tick();
        end
        rsp_ready = 4'hF;
        #1;
        chk("bp_release_unit_out_ready", 64'(unit_out_ready), 64'd1);
        tick();
        man_dat = 32'hBEEF_0003;
        #1;
        chk("bp_pop_outstanding", 64'(outstanding), 64'd3);
        chk("bp_next_head", 64'(rsp_valid), 64'b1000);
        tick();

        // Simultaneous issue (req 2) and response (tag 0) at outstanding=2.
        req_valid = 4'b0100;
        #1;
        chk("sim_outstanding_before", 64'(outstanding), 64'd2);
        chk("sim_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("sim_req_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'h0;
        #1;
        chk("sim_outstanding_after", 64'(outstanding), 64'd2);
        chk("sim_order_1", 64'(rsp_valid), 64'b0010);
        tick();
        #1;
        chk("sim_order_2", 64'(rsp_valid), 64'b0100);
        tick();
        man_vld = 1'b0;
        #1;
        chk("sim_drained", 64'(outstanding), 64'd0);

        // Protocol error: result with nothing pending.
        man_vld = 1'b1;
        #1;
        chk("perr_unit_out_ready", 64'(unit_out_ready), 64'd0);
        chk("perr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("perr_not_yet", 64'(proto_err), 64'd0);
        tick();
        man_vld = 1'b0;
        #1;
        chk("perr_set", 64'(proto_err), 64'd1);
        tick();
        #1;
        chk("perr_sticky", 64'(proto_err), 64'd1);

        // Reset with three in flight (grants 3,0,1 leave rr_ptr at 2).
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'hF;
            tick();
        end
        req_valid = 4'h0;
        #1;
        chk("pre_reset_outstanding", 64'(outstanding), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'hF;
        unit_in_ready = 1'b0;
        #1;
        chk("post_reset_outstanding", 64'(outstanding), 64'd0);
        chk("post_reset_proto_err", 64'(proto_err), 64'd0);
        chk("post_reset_req_ready", 64'(req_ready), 64'd0);
        chk("post_reset_unit_in_valid", 64'(unit_in_valid), 64'd1);
        chk("post_reset_rr_ptr", unit_in_data, pat(0));
        tick();

        // req_valid=1010 held: fixed priority starves 3, round-robin alternates.
`ifdef FP_ARB_FIXED_PRIO_EN
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
        exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`endif
        unit_in_ready = 1'b1;
        rsp_ready = 4'hF;
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'b1010;
            man_vld = (c > 0);
            #1;
            chk("prio_req_ready", 64'(req_ready), 64'(exp_g[c]));
            chk("prio_outstanding", 64'(outstanding), (c == 0) ? 64'd0 : 64'd1);
            if (c > 0) chk("prio_rsp_valid", 64'(rsp_valid), 64'(exp_g[c-1]));
            tick();
        end
        req_valid = 4'h0;
        man_vld = 1'b1;
        #1;
        chk("prio_last_rsp_valid", 64'(rsp_valid), 64'(exp_g[3]));
        tick();
        man_vld = 1'b0;
        #1;
        chk("final_outstanding", 64'(outstanding), 64'd0);
        chk("final_proto_err", 64'(proto_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
